// File: rtl/spio_hss_multiplexer_handshake_ctrl.sv
// HSS link handshake sequencer: PHASE0 -> PHASE1 -> COMPLETE, with error/remote restart and status.
// Define SPIO_HSS_HANDSHAKE_TIMEOUT_EN to build the stalled-handshake timeout back to PHASE0.

`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h01
`endif

module spio_hss_multiplexer_handshake_ctrl #(
    parameter int HANDSHAKE_TIMEOUT = 1000,
    parameter int TIMEOUT_BITS      = 10,
    parameter int PHASE1_HOLD       = 16,
    parameter int ERROR_LIMIT       = 8
) (
    input  logic       CLK_IN,
    input  logic       RESET_IN,
    input  logic       RX_HS_VLD_IN,
    input  logic       RX_HS_PHASE_IN,
    input  logic [7:0] RX_HS_VERSION_IN,
    input  logic       RX_GOOD_IN,
    input  logic       RX_ERR_IN,
    output logic       HANDSHAKE_COMPLETE_OUT,
    output logic       HANDSHAKE_PHASE_OUT,
    output logic       VERSION_MISMATCH_OUT,
    output logic [7:0] RESTART_CNT_OUT
);

    // Bit 1 is the link-up flag and bit 0 the advertised phase, so both outputs come straight from flops.
    localparam logic [1:0] ST_PHASE0   = 2'b00;
    localparam logic [1:0] ST_PHASE1   = 2'b01;
    localparam logic [1:0] ST_COMPLETE = 2'b11;

    localparam logic [4:0] HOLD_TARGET = 5'(PHASE1_HOLD);
    localparam logic [4:0] HOLD_MAX    = 5'd31;
    localparam logic [3:0] ERR_LAST    = 4'(ERROR_LIMIT - 1);

    logic [1:0] state, state_nxt;
    logic [4:0] hold_cnt, hold_nxt;
    logic       seen_p1, seen_nxt;
    logic [3:0] err_cnt, err_nxt;
    logic [7:0] restart_cnt, restart_nxt;
    logic       mismatch, mismatch_nxt;

    logic hs_valid;
    logic p0_word;
    logic p1_word;
    logic seen_now;
    logic err_limit;
    logic timeout_hit;

    assign hs_valid  = RX_HS_VLD_IN && (RX_HS_VERSION_IN == `PROTOCOL_VERSION);
    assign p0_word   = hs_valid && !RX_HS_PHASE_IN;
    assign p1_word   = hs_valid && RX_HS_PHASE_IN;
    assign seen_now  = seen_p1 || p1_word;
    assign err_limit = RX_ERR_IN && (err_cnt == ERR_LAST);

`ifdef SPIO_HSS_HANDSHAKE_TIMEOUT_EN
    localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_LAST = TIMEOUT_BITS'(HANDSHAKE_TIMEOUT - 1);
    logic [TIMEOUT_BITS-1:0] timeout_cnt;

    // Gating on !hs_valid lets a valid word in the expiry cycle win over the timeout.
    assign timeout_hit = (state != ST_COMPLETE) && !hs_valid && (timeout_cnt == TIMEOUT_LAST);

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN)
            timeout_cnt <= '0;
        else if ((state == ST_COMPLETE) || hs_valid || timeout_hit)
            timeout_cnt <= '0;
        else
            timeout_cnt <= timeout_cnt + TIMEOUT_BITS'(1);
    end
`else
    // Keeps the timeout parameters referenced when the feature is compiled out.
    localparam int unused_timeout_cfg = HANDSHAKE_TIMEOUT + TIMEOUT_BITS;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        hold_nxt     = '0;
        seen_nxt     = 1'b0;
        err_nxt      = '0;
        restart_nxt  = restart_cnt;
        mismatch_nxt = RX_HS_VLD_IN ? !hs_valid : mismatch;

        case (state)
            ST_PHASE0: begin
                if (hs_valid) begin
                    state_nxt = ST_PHASE1;
                    hold_nxt  = 5'd1;
                end
            end
            ST_PHASE1: begin
                seen_nxt = seen_now;
                if (p0_word)
                    hold_nxt = 5'd1;
                else if (seen_now && (hold_cnt >= HOLD_TARGET)) begin
                    state_nxt = ST_COMPLETE;
                    seen_nxt  = 1'b0;
                end else
                    hold_nxt = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + 5'd1;
            end
            ST_COMPLETE: begin
                if (RX_ERR_IN)
                    err_nxt = err_cnt + 4'd1;
                else if (!RX_GOOD_IN)
                    err_nxt = err_cnt;
                // A remote restart and the error limit together still make one exit.
                if (p0_word || err_limit) begin
                    state_nxt = ST_PHASE0;
                    err_nxt   = '0;
                    if (restart_cnt != 8'hFF)
                        restart_nxt = restart_cnt + 8'd1;
                end
            end
            default: state_nxt = ST_PHASE0;
        endcase

        if (timeout_hit) begin
            state_nxt = ST_PHASE0;
            hold_nxt  = '0;
            seen_nxt  = 1'b0;
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RESET_IN) begin
            state       <= ST_PHASE0;
            hold_cnt    <= '0;
            seen_p1     <= 1'b0;
            err_cnt     <= '0;
            restart_cnt <= '0;
            mismatch    <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            seen_p1     <= seen_nxt;
            err_cnt     <= err_nxt;
            restart_cnt <= restart_nxt;
            mismatch    <= mismatch_nxt;
        end
    end

    assign HANDSHAKE_COMPLETE_OUT = state[1];
    assign HANDSHAKE_PHASE_OUT    = state[0];
    assign VERSION_MISMATCH_OUT   = mismatch;
    assign RESTART_CNT_OUT        = restart_cnt;

endmodule

// File: tb/tb_spio_hss_multiplexer_handshake_ctrl.sv
// Scoreboard bench for spio_hss_multiplexer_handshake_ctrl; timeout scenario runs when
// SPIO_HSS_HANDSHAKE_TIMEOUT_EN is defined, otherwise an indefinite-wait scenario runs.

`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h01
`endif

module tb_spio_hss_multiplexer_handshake_ctrl;

    localparam int HOLD = 16;
    localparam int TMO  = 1000;
    localparam logic [7:0] PV      = `PROTOCOL_VERSION;
    localparam logic [7:0] BAD_VER = PV + 8'd1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld   = 1'b0;
    logic       ph    = 1'b0;
    logic [7:0] ver   = PV;
    logic       good  = 1'b0;
    logic       err   = 1'b0;
    logic       complete;
    logic       phase;
    logic       mismatch;
    logic [7:0] restart_cnt;

    typedef struct packed {
        logic       complete;
        logic       phase;
        logic       mismatch;
        logic [7:0] cnt;
    } obs_t;

    obs_t sb[$];
    obs_t got;
    obs_t want;
    int   compared   = 0;
    int   mismatched = 0;

    spio_hss_multiplexer_handshake_ctrl dut (
        .CLK_IN                 (clk),
        .RESET_IN               (rst_n),
        .RX_HS_VLD_IN           (vld),
        .RX_HS_PHASE_IN         (ph),
        .RX_HS_VERSION_IN       (ver),
        .RX_GOOD_IN             (good),
        .RX_ERR_IN              (err),
        .HANDSHAKE_COMPLETE_OUT (complete),
        .HANDSHAKE_PHASE_OUT    (phase),
        .VERSION_MISMATCH_OUT   (mismatch),
        .RESTART_CNT_OUT        (restart_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: run still active at time %0t, required finish before 3000000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t mk(input logic c, input logic p, input logic m, input int n);
        mk = {c, p, m, 8'((n > 255) ? 255 : n)};
    endfunction

    function automatic obs_t sample();
        sample = {complete, phase, mismatch, restart_cnt};
    endfunction

    // One clock of stimulus; returns 1 time unit after the edge that sampled it.
    task automatic drive(input logic v, input logic p, input logic [7:0] vr, input logic g, input logic e);
        vld = v; ph = p; ver = vr; good = g; err = e;
        @(posedge clk);
        #1;
        vld = 1'b0; ph = 1'b0; ver = PV; good = 1'b0; err = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic reach_complete();
        repeat (1 + HOLD) drive(1'b1, 1'b1, PV, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        sb.push_back(mk(0, 0, 0, 0));
        want = sb.pop_front(); got = sample(); compared++;
        if (got !== want) begin mismatched++; $display("FAIL reset_asserted: got %p, expected %p", got, want); end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sb.push_back(mk(0, 0, 0, 0));
            drive(1'b0, 1'b0, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL reset_idle[%0d]: got %p, expected %p", i, got, want); end
        end
    endtask

    task automatic test_bring_up();
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            // Cycles 0..9 idle, cycle 10 carries the phase-0 word, cycle 11 is the idle entry cycle.
            sb.push_back(mk(0, i == 10, 0, 0));
            drive(i == 10, 1'b0, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL bringup_pre[%0d]: got %p, expected %p", i, got, want); end
        end
        sb.push_back(mk(0, 1, 0, 0));
        drive(1'b0, 1'b0, PV, 1'b0, 1'b0);
        want = sb.pop_front(); got = sample(); compared++;
        if (got !== want) begin mismatched++; $display("FAIL bringup_entry: got %p, expected %p", got, want); end
        for (int j = 1; j <= HOLD + 2; j++) begin
            sb.push_back(mk(j >= HOLD - 1, 1, 0, 0));
            drive(1'b1, 1'b1, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL bringup_p1[%0d]: got %p, expected %p", j, got, want); end
        end
    endtask

    task automatic test_hold_restart();
        apply_reset();
        // The word that leaves PHASE0 does not count as a phase-1 word seen inside PHASE1.
        for (int i = 0; i < 22; i++) begin
            sb.push_back(mk(i == 21, 1, 0, 0));
            drive(i == 0 || i == 21, 1'b1, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL seen_required[%0d]: got %p, expected %p", i, got, want); end
        end
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            // Entry word, 8 phase-1 words, then a phase-0 word that restarts the hold count.
            sb.push_back(mk(0, 1, 0, 0));
            drive(1'b1, i != 9, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL hold_pre[%0d]: got %p, expected %p", i, got, want); end
        end
        for (int j = 1; j <= HOLD; j++) begin
            sb.push_back(mk(j == HOLD, 1, 0, 0));
            drive(1'b0, 1'b0, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL hold_restart[%0d]: got %p, expected %p", j, got, want); end
        end
    endtask

    task automatic test_version_mismatch();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            // Foreign word, idle (sticky), valid word, foreign word in PHASE1.
            sb.push_back(mk(0, i >= 2, i != 2, 0));
            drive(i != 1, 1'b1, (i == 2) ? PV : BAD_VER, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL version[%0d]: got %p, expected %p", i, got, want); end
        end
    endtask

    task automatic test_error_restart();
        apply_reset();
        reach_complete();
        for (int i = 1; i <= 8; i++) begin
            // Seven errors, then a good word that clears the count.
            sb.push_back(mk(1, 1, 0, 0));
            drive(1'b0, 1'b0, PV, i == 8, i != 8);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL err_first7[%0d]: got %p, expected %p", i, got, want); end
        end
        for (int i = 1; i <= 8; i++) begin
            sb.push_back(mk(i < 8, i < 8, 0, i == 8));
            drive(1'b0, 1'b0, PV, 1'b0, 1'b1);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL err_limit[%0d]: got %p, expected %p", i, got, want); end
        end
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk(0, 0, 0, 1));
            drive(1'b0, 1'b0, PV, 1'b0, 1'b1);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL err_outside[%0d]: got %p, expected %p", i, got, want); end
        end
        for (int r = 0; r < 2; r++) begin
            reach_complete();
            for (int i = 1; i <= 8; i++) begin
                // 8th cycle: error with good (r=0) or error with a phase-0 word (r=1), one restart either way.
                sb.push_back(mk(i < 8, i < 8, 0, (i == 8) ? r + 2 : r + 1));
                drive(i == 8 && r == 1, 1'b0, PV, i == 8 && r == 0, 1'b1);
                want = sb.pop_front(); got = sample(); compared++;
                if (got !== want) begin mismatched++; $display("FAIL err_combo%0d[%0d]: got %p, expected %p", r, i, got, want); end
            end
        end
    endtask

    task automatic test_remote_restart();
        apply_reset();
        for (int i = 1; i <= 300; i++) begin
            reach_complete();
            sb.push_back(mk(1, 1, 0, i - 1));
            drive(1'b1, 1'b1, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL remote_complete[%0d]: got %p, expected %p", i, got, want); end
            sb.push_back(mk(0, 0, 0, i));
            drive(1'b1, 1'b0, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL remote_restart[%0d]: got %p, expected %p", i, got, want); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        reach_complete();
        drive(1'b1, 1'b0, PV, 1'b0, 1'b0);
        drive(1'b1, 1'b1, PV, 1'b0, 1'b0);
        sb.push_back(mk(0, 1, 1, 1));
        drive(1'b1, 1'b1, BAD_VER, 1'b0, 1'b0);
        want = sb.pop_front(); got = sample(); compared++;
        if (got !== want) begin mismatched++; $display("FAIL reset_mid_pre: got %p, expected %p", got, want); end
        #2 rst_n = 1'b0;
        sb.push_back(mk(0, 0, 0, 0));
        #1;
        want = sb.pop_front(); got = sample(); compared++;
        if (got !== want) begin mismatched++; $display("FAIL reset_mid_async: got %p, expected %p", got, want); end
        @(negedge clk) rst_n = 1'b1;
    endtask

`ifdef SPIO_HSS_HANDSHAKE_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        for (int j = 0; j <= TMO; j++) begin
            sb.push_back(mk(0, j < TMO, 0, 0));
            drive(j == 0, 1'b1, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL timeout_expire[%0d]: got %p, expected %p", j, got, want); end
        end
        for (int j = 0; j <= TMO; j++) begin
            // Re-enter PHASE1, then a valid phase-0 word lands exactly on the expiry cycle.
            sb.push_back(mk(0, 1, 0, 0));
            drive(j == 0 || j == TMO, j == 0, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL timeout_rescue[%0d]: got %p, expected %p", j, got, want); end
        end
        for (int j = 1; j <= TMO; j++) begin
            sb.push_back(mk(0, j < TMO, 0, 0));
            drive(1'b0, 1'b0, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL timeout_after[%0d]: got %p, expected %p", j, got, want); end
        end
    endtask
`else
    task automatic test_no_timeout();
        apply_reset();
        for (int j = 0; j <= TMO + 100; j++) begin
            sb.push_back(mk(0, 1, 0, 0));
            drive(j == 0, 1'b1, PV, 1'b0, 1'b0);
            want = sb.pop_front(); got = sample(); compared++;
            if (got !== want) begin mismatched++; $display("FAIL no_timeout[%0d]: got %p, expected %p", j, got, want); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bring_up();
        test_hold_restart();
        test_version_mismatch();
        test_error_restart();
        test_remote_restart();
        test_reset_mid();
`ifdef SPIO_HSS_HANDSHAKE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spio_hss_multiplexer_handshake_ctrl.md
# spio_hss_multiplexer_handshake_ctrl

Sequences the link handshake for the HSS multiplexer. It decides when the transmit controller sends handshake words and which phase they carry, and when the link is declared up. It consumes handshake/error indications from the receive side and drives the handshake-complete and phase inputs of the transmit controller. It also restarts the handshake on link errors, remote restart or stalled progress, and exports status for the register bank.

## Interface
Parameters:
- HANDSHAKE_TIMEOUT, 1000: cycles in PHASE0/PHASE1 without a valid handshake word before forcing PHASE0.
- TIMEOUT_BITS, 10: width of the timeout counter; must hold HANDSHAKE_TIMEOUT.
- PHASE1_HOLD, 16: minimum cycles spent in PHASE1 before COMPLETE (1..31).
- ERROR_LIMIT, 8: consecutive-error count in COMPLETE that forces restart (1..15).

Ports:
- CLK_IN  in  1  clock.
- RESET_IN  in  1  asynchronous, active-low reset.
- RX_HS_VLD_IN  in  1  one-cycle pulse: handshake word received.
- RX_HS_PHASE_IN  in  1  phase bit of the received handshake word.
- RX_HS_VERSION_IN  in  8  protocol version of the received handshake word.
- RX_GOOD_IN  in  1  error-free word received this cycle.
- RX_ERR_IN  in  1  errored/out-of-sync word received this cycle.
- HANDSHAKE_COMPLETE_OUT  out  1  link up; to transmit controller.
- HANDSHAKE_PHASE_OUT  out  1  phase to advertise in transmitted handshake words.
- VERSION_MISMATCH_OUT  out  1  sticky: last handshake word had a foreign version.
- RESTART_CNT_OUT  out  8  saturating count of COMPLETE→PHASE0 exits.

## Operation
- A word is *valid* when RX_HS_VLD_IN=1 and RX_HS_VERSION_IN == `PROTOCOL_VERSION. Words with a foreign version set VERSION_MISMATCH_OUT and cause no state change. A valid word clears VERSION_MISMATCH_OUT.
- States:
  - PHASE0 (COMPLETE=0, PHASE=0).
  - PHASE1 (COMPLETE=0, PHASE=1).
  - COMPLETE (COMPLETE=1, PHASE=1).
- PHASE0 → PHASE1: on any valid word, either phase.
- PHASE1 → COMPLETE: a valid phase-1 word has been seen since entering PHASE1, and the hold counter ≥ PHASE1_HOLD. Both are required; the seen flag is latched.
- PHASE1 on a valid phase-0 word: stay in PHASE1. The hold counter restarts.
- PHASE0/PHASE1 timeout: the timeout counter clears on entry and on every valid word, and increments otherwise. Reaching HANDSHAKE_TIMEOUT forces PHASE0 and clears all counters. From PHASE0 this re-enters PHASE0.
- COMPLETE → PHASE0 on either:
  - a valid phase-0 word (remote restarted), or
  - the error counter reaching ERROR_LIMIT.
  - RESTART_CNT_OUT increments by one per exit, saturating at 255.
- Error counter:
  - Active only in COMPLETE; held at 0 elsewhere.
  - RX_ERR_IN=1 increments it; RX_GOOD_IN=1 with RX_ERR_IN=0 clears it.
  - Both asserted together: the error wins.
- Valid phase-1 words in COMPLETE are ignored.

## Timing
- All outputs are registered.
- A state change takes effect in the cycle after the triggering input; outputs reflect the new state in that same cycle.
- Reset values: HANDSHAKE_COMPLETE_OUT=0, HANDSHAKE_PHASE_OUT=0, VERSION_MISMATCH_OUT=0, RESTART_CNT_OUT=0. State=PHASE0; all counters 0.
- Reset asserted mid-handshake or in COMPLETE returns immediately (asynchronously) to the reset values.
- Simultaneous events:
  - Valid word and timeout expiry in the same cycle: the valid word wins; the counter clears.
  - Phase-0 word and error limit in the same cycle in COMPLETE: a single restart, counted once.
- Minimum PHASE0→COMPLETE latency with back-to-back valid phase-1 words: 1 + PHASE1_HOLD cycles.

## Configuration
- SPIO_HSS_HANDSHAKE_TIMEOUT_EN
  - Defined: the timeout counter and forced return to PHASE0 are implemented as above.
  - Undefined: no timeout logic. PHASE0/PHASE1 wait indefinitely for valid words; HANDSHAKE_TIMEOUT and TIMEOUT_BITS are unused.

## Test plan
- **Reset:** release reset, no RX activity → COMPLETE=0, PHASE=0, MISMATCH=0, RESTART_CNT=0 throughout. With macro defined, the state stays PHASE0; each timeout re-enters PHASE0.
- **Normal bring-up:** one valid phase-0 word at cycle 10 → PHASE=1 at cycle 11. Valid phase-1 words every cycle from 12 → COMPLETE=1 exactly 16 cycles after entering PHASE1.
- **Version mismatch:** a handshake word with version `PROTOCOL_VERSION+1 in PHASE0 → MISMATCH=1, state stays PHASE0. A following valid word → MISMATCH=0, PHASE=1.
- **Error restart:** in COMPLETE, apply 7 RX_ERR_IN pulses, then RX_GOOD_IN, then 8 RX_ERR_IN pulses → no restart after the first 7. After the 8th consecutive error: COMPLETE=0, PHASE=0, RESTART_CNT=1. Assert RX_ERR_IN and RX_GOOD_IN together → counted as an error.
- **Timeout (macro defined):** enter PHASE1, then no valid words for 1000 cycles → PHASE=0. A valid word on the expiry cycle instead → stays PHASE1.
- **Remote restart and saturation:** a valid phase-0 word in COMPLETE → PHASE0, RESTART_CNT+1. Repeat 300 restarts → RESTART_CNT_OUT=255. Assert reset mid-PHASE1 → all outputs 0 immediately.
